// File: rtl/lcd_pkg.sv
// Shared definitions for the DE-mode LCD video path: receiver state
// encoding, default 800x480 panel timing (also used by the DE timing
// generators) and CRC-16-CCITT constants.
package lcd_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // 800x480 panel: 1057-clock lines (800 active + 257 blank), 480 lines.
  localparam logic [10:0] LCD_H_VALID   = 11'd800;
  localparam logic [10:0] LCD_V_VALID   = 11'd480;
  localparam logic [10:0] LCD_H_SYNC    = 11'd1;
  localparam logic [10:0] LCD_H_BACK    = 11'd46;
  localparam logic [10:0] LCD_H_FRONT   = 11'd210;

  // Longer than any horizontal blank, shorter than the vertical blank.
  localparam logic [11:0] LCD_VBLANK_TH = 12'd2048;

  localparam logic [15:0] LCD_CRC16_POLY = 16'h1021;
  localparam logic [15:0] LCD_CRC16_INIT = 16'hFFFF;

  // 11-bit increment that sticks at all-ones.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/lcd_crc16_step.sv
// Combinational CRC-16-CCITT update consuming one 16-bit word per call,
// MSB first (polynomial from lcd_pkg).
// Ports:
//   crc_in   current CRC register
//   data_in  16-bit word to absorb
//   crc_out  CRC after absorbing data_in
module lcd_crc16_step
  import lcd_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc;
  logic [15:0] dat;
  logic        fb;

  always_comb begin
    crc = crc_in;
    dat = data_in;
    fb  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      fb  = crc[15] ^ dat[15];
      crc = {crc[14:0], 1'b0} ^ (fb ? LCD_CRC16_POLY : '0);
      dat = {dat[14:0], 1'b0};
    end
    crc_out = crc;
  end

endmodule

// File: rtl/lcd_de_rx.sv
// DE-mode LCD video receiver. Samples DE + RGB565 in the pixel clock
// domain, recovers pixel X/Y, frame_start/frame_end markers, measured
// active width/height, and reports lock once a whole frame matches
// H_VALID x V_VALID.
// Ports:
//   lcd_clk        pixel clock
//   sys_rst        synchronous reset, active-high
//   de_in/data_in  incoming data enable and RGB565 pixel
//   pix_valid      registered DE, suppressed while searching for frame sync
//   pix_data       registered data_in
//   pixel_xpos/ypos  column/line of pix_data
//   frame_start    pulse with the first pixel of a frame
//   frame_end      pulse when vertical blank is detected
//   locked         last completed frame matched the expected geometry
//   h_active_meas  DE-high length of the last completed line
//   v_active_meas  line count of the last completed frame
// Optional (LCD_DE_RX_CRC_EN defined):
//   frame_crc/frame_crc_valid  CRC-16-CCITT over the frame's pixels,
//   presented together with frame_end.
module lcd_de_rx
  import lcd_pkg::*;
#(
  parameter logic [10:0] H_VALID   = LCD_H_VALID,
  parameter logic [10:0] V_VALID   = LCD_V_VALID,
  parameter logic [11:0] VBLANK_TH = LCD_VBLANK_TH
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        de_in,
  input  logic [15:0] data_in,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic        frame_end,
  output logic        locked,
  output logic [10:0] h_active_meas,
  output logic [10:0] v_active_meas
`ifdef LCD_DE_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid
`endif
);

  rx_state_t   state_q, state_d;
  logic        de_q;
  logic [11:0] low_cnt;
  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic        line_err;
  logic        sof_armed;

  logic        rise, fall, vblank, sync_on, geom_ok;
  logic [10:0] x_cur;
  logic [11:0] run_len;
  logic [10:0] run_meas;

  assign rise    = de_in & ~de_q;
  assign fall    = ~de_in & de_q;
  // low_cnt saturates at VBLANK_TH, so this fires once per low run.
  assign vblank  = ~de_in & (low_cnt == VBLANK_TH - 12'd1);
  assign sync_on = (state_q != SEARCH);
  assign geom_ok = ~line_err & (y_cnt == V_VALID);

  // Column of the pixel being sampled this cycle.
  assign x_cur    = rise ? '0 : sat_inc11(x_cnt);
  // x_cnt holds the last column of the run that just ended.
  assign run_len  = {1'b0, x_cnt} + 12'd1;
  assign run_meas = run_len[11] ? 11'h7FF : run_len[10:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vblank)             state_d = SYNC;
      SYNC:    if (vblank && geom_ok)  state_d = LOCKED;
      LOCKED:  if (vblank && !geom_ok) state_d = SYNC;
      default:                         state_d = SEARCH;
    endcase
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state_q       <= SEARCH;
      de_q          <= 1'b0;
      low_cnt       <= '0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      line_err      <= 1'b0;
      sof_armed     <= 1'b0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pixel_xpos    <= '0;
      pixel_ypos    <= '0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      locked        <= 1'b0;
      h_active_meas <= '0;
      v_active_meas <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= de_in;

      if (de_in)
        low_cnt <= '0;
      else if (low_cnt != VBLANK_TH)
        low_cnt <= low_cnt + 12'd1;

      if (de_in)
        x_cnt <= x_cur;

      if (fall)
        y_cnt <= sat_inc11(y_cnt);
      else if (vblank)
        y_cnt <= '0;

      if (vblank)
        line_err <= 1'b0;
      else if (fall && (run_len != {1'b0, H_VALID}))
        line_err <= 1'b1;

      if (vblank)
        sof_armed <= 1'b1;
      else if (rise)
        sof_armed <= 1'b0;

      pix_valid   <= de_in & sync_on;
      pix_data    <= data_in;
      frame_start <= rise & sof_armed & sync_on;
      frame_end   <= vblank & sync_on;

      if (de_in) begin
        pixel_xpos <= x_cur;
        pixel_ypos <= y_cnt;
      end

      if (fall)
        h_active_meas <= run_meas;

      if (vblank && sync_on) begin
        v_active_meas <= y_cnt;
        locked        <= geom_ok;
      end
    end
  end

`ifdef LCD_DE_RX_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_seed;
  logic [15:0] crc_next;

  // frame_start only ever accompanies pix_valid, so the seed swap lands
  // exactly on the frame's first pixel.
  assign crc_seed = frame_start ? LCD_CRC16_INIT : crc_q;

  lcd_crc16_step u_crc16_step (
    .crc_in  (crc_seed),
    .data_in (pix_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      crc_q           <= LCD_CRC16_INIT;
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
    end else begin
      if (pix_valid)
        crc_q <= crc_next;
      frame_crc_valid <= vblank & sync_on;
      if (vblank && sync_on)
        frame_crc <= crc_q;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_de_rx.sv
// Directed bench for lcd_de_rx on a reduced 16x6 geometry (5-clock
// horizontal blank, 45-clock vertical blank, VBLANK_TH = 32).
module tb_lcd_de_rx;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int TH = 32;
  localparam int HB = 5;
  localparam int VB = 45;

  logic        lcd_clk = 1'b0;
  logic        sys_rst;
  logic        de_in;
  logic [15:0] data_in;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        frame_start, frame_end, locked;
  logic [10:0] h_active_meas, v_active_meas;
`ifdef LCD_DE_RX_CRC_EN
  logic [15:0] frame_crc;
  logic        frame_crc_valid;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  bit          cur_lock, exp_lock;
  int          exp_v;
  bit          fill_en;
  logic [15:0] fill_val;
  logic [15:0] exp_crc;

  lcd_de_rx #(
    .H_VALID   (11'd16),
    .V_VALID   (11'd6),
    .VBLANK_TH (12'd32)
  ) dut (
    .lcd_clk         (lcd_clk),
    .sys_rst         (sys_rst),
    .de_in           (de_in),
    .data_in         (data_in),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .pixel_xpos      (pixel_xpos),
    .pixel_ypos      (pixel_ypos),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .locked          (locked),
    .h_active_meas   (h_active_meas),
    .v_active_meas   (v_active_meas)
`ifdef LCD_DE_RX_CRC_EN
    ,
    .frame_crc       (frame_crc),
    .frame_crc_valid (frame_crc_valid)
`endif
  );

  always #5 lcd_clk = ~lcd_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int x, input int y);
    logic [15:0] v;
    v = 16'(y * 37 + x * 3);
    return v ^ 16'h5A5A;
  endfunction

  // Bit-serial CRC-16-CCITT reference, MSB first.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Apply one input cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic de, input logic [15:0] d);
    de_in   = de;
    data_in = d;
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_pix_valid", pix_valid, 0);
    check_val("rst_pix_data", pix_data, 0);
    check_val("rst_xpos", pixel_xpos, 0);
    check_val("rst_ypos", pixel_ypos, 0);
    check_val("rst_frame_start", frame_start, 0);
    check_val("rst_frame_end", frame_end, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_h_meas", h_active_meas, 0);
    check_val("rst_v_meas", v_active_meas, 0);
`ifdef LCD_DE_RX_CRC_EN
    check_val("rst_frame_crc", frame_crc, 0);
    check_val("rst_crc_valid", frame_crc_valid, 0);
`endif
  endtask

  task automatic send_line(input int len, input int y, input bit vis, input bit first,
                           input int low_n, input int fe_at);
    logic [15:0] d;
    for (int x = 0; x < len; x++) begin
      d = fill_en ? fill_val : pat(x, y);
      drive(1'b1, d);
      if (vis) begin
        check_val("pix_valid", pix_valid, 1);
        check_val("xpos", pixel_xpos, x);
        check_val("ypos", pixel_ypos, y);
        check_val("pix_data", pix_data, d);
        check_val("frame_start", frame_start, (first && x == 0) ? 1 : 0);
        if (first && x == 0) exp_crc = 16'hFFFF;
        exp_crc = crc_model(exp_crc, d);
      end else begin
        check_val("pix_suppressed", pix_valid, 0);
        check_val("frame_start_suppressed", frame_start, 0);
      end
    end
    for (int k = 1; k <= low_n; k++) begin
      drive(1'b0, 16'h0000);
      if (k == 1) check_val("h_active_meas", h_active_meas, len);
      check_val("pix_valid_blank", pix_valid, 0);
      check_val("frame_end", frame_end, (k == fe_at) ? 1 : 0);
      if (k == fe_at) begin
        check_val("locked_at_end", locked, exp_lock);
        check_val("v_active_meas", v_active_meas, exp_v);
        cur_lock = exp_lock;
`ifdef LCD_DE_RX_CRC_EN
        check_val("crc_valid", frame_crc_valid, 1);
        check_val("frame_crc", frame_crc, exp_crc);
`endif
      end else begin
        check_val("locked_hold", locked, cur_lock);
`ifdef LCD_DE_RX_CRC_EN
        check_val("crc_valid_idle", frame_crc_valid, 0);
`endif
      end
    end
  endtask

  task automatic send_frame(input int nlines, input int short_y, input int long_hb_y, input bit vis);
    int len, low_n, fe_at;
    bit last;
    for (int y = 0; y < nlines; y++) begin
      len   = (y == short_y) ? H - 1 : H;
      last  = (y == nlines - 1);
      low_n = last ? VB : ((y == long_hb_y) ? TH - 1 : HB);
      fe_at = (last && vis) ? TH : 0;
      send_line(len, y, vis, y == 0, low_n, fe_at);
    end
  endtask

  initial begin
    fill_en  = 1'b0;
    fill_val = 16'h0000;
    exp_crc  = 16'hFFFF;
    cur_lock = 1'b0;
    exp_lock = 1'b0;
    exp_v    = 0;
    de_in    = 1'b0;
    data_in  = 16'h0000;

    sys_rst = 1'b1;
    repeat (3) drive(1'b0, 16'h1234);
    check_reset_outputs();
    sys_rst = 1'b0;

    // Frame 1 discarded while searching; frame 2 locks, frame 3 stays locked.
    send_frame(V, -1, -1, 1'b0);
    exp_lock = 1'b1; exp_v = V;
    send_frame(V, -1, -1, 1'b1);
    send_frame(V, -1, -1, 1'b1);

    // One short line drops lock at frame end; next good frame relocks.
    exp_lock = 1'b0; exp_v = V;
    send_frame(V, 2, -1, 1'b1);
    exp_lock = 1'b1; exp_v = V;
    send_frame(V, -1, -1, 1'b1);

    // One extra line.
    exp_lock = 1'b0; exp_v = V + 1;
    send_frame(V + 1, -1, -1, 1'b1);

    // Good frame with an H-blank of TH-1 low cycles: no early frame_end.
    exp_lock = 1'b1; exp_v = V;
    send_frame(V, -1, 2, 1'b1);

    // Reset in the middle of line 3.
    for (int y = 0; y < 3; y++) send_line(H, y, 1'b1, y == 0, HB, 0);
    for (int x = 0; x < 5; x++) begin
      drive(1'b1, pat(x, 3));
      check_val("pre_rst_xpos", pixel_xpos, x);
    end
    sys_rst = 1'b1;
    drive(1'b1, pat(5, 3));
    sys_rst = 1'b0;
    check_reset_outputs();
    cur_lock = 1'b0;
    send_line(H - 6, 3, 1'b0, 1'b0, HB, 0);
    send_line(H, 4, 1'b0, 1'b0, HB, 0);
    send_line(H, 5, 1'b0, 1'b0, VB, 0);
    exp_lock = 1'b1; exp_v = V;
    send_frame(V, -1, -1, 1'b1);

    // DE held high through reset release.
    sys_rst = 1'b1;
    drive(1'b1, 16'hBEEF);
    drive(1'b1, 16'hBEEF);
    sys_rst = 1'b0;
    check_reset_outputs();
    cur_lock = 1'b0;
    send_frame(V, -1, -1, 1'b0);
    exp_lock = 1'b1; exp_v = V;
    send_frame(V, -1, -1, 1'b1);

`ifdef LCD_DE_RX_CRC_EN
    // Constant-pixel frames.
    fill_en = 1'b1;
    fill_val = 16'h0000;
    send_frame(V, -1, -1, 1'b1);
    fill_val = 16'hFFFF;
    send_frame(V, -1, -1, 1'b1);
    fill_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
